attack_fsm: RTL and testbench

- Attacker-side counterpart to the per-player hit/damage tracker.
- Sequences one player's attack through startup, active and recovery frames.
- During active frames, tests the hitbox against the opponent's hurtbox and emits at most one hit pulse plus damage value per attack.
- The hit pulse and damage drive the opponent's got_hit / hit_damage_in inputs directly; the local hit_stun_active feeds back as `stunned` to cancel or block attacks.

---
 rtl/attack_fsm.sv | 165 ++++++++++++++++
 tb/tb_attack_fsm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/attack_fsm.sv
// Attacker-side attack sequencer: startup/active/recovery phases driven by frame_tick,
// hitbox-vs-hurtbox overlap test, and a single one-clk hit pulse with damage per attack.
module attack_fsm #(
   parameter int STARTUP_FRAMES  = 4,
   parameter int ACTIVE_FRAMES   = 3,
   parameter int RECOVERY_FRAMES = 8,
   parameter int JAB_DAMAGE      = 6,
   parameter int SMASH_DAMAGE    = 14,
   parameter int JAB_REACH       = 20,
   parameter int SMASH_REACH     = 32,
   parameter int HITBOX_HALF_H   = 16,
   parameter int HURTBOX_HALF_W  = 12
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       attack_btn,
   input  logic       attack_type,
   input  logic       facing,
   input  logic       stunned,
   input  logic [9:0] atk_x,
   input  logic [9:0] atk_y,
   input  logic [9:0] def_x,
   input  logic [9:0] def_y,
   output logic       hit_out,
   output logic [5:0] hit_damage_out,
   output logic [1:0] attack_phase,
   output logic       attack_busy
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_STARTUP  = 2'd1;
   localparam logic [1:0] S_ACTIVE   = 2'd2;
   localparam logic [1:0] S_RECOVERY = 2'd3;

   localparam int CW = 8;
   localparam logic [CW-1:0] CNT_STARTUP  = CW'(STARTUP_FRAMES);
   localparam logic [CW-1:0] CNT_ACTIVE   = CW'(ACTIVE_FRAMES);
   localparam logic [CW-1:0] CNT_RECOVERY = CW'(RECOVERY_FRAMES);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   logic [1:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          pending, pending_n;
   logic          hit_done, hit_done_n;
   logic          type_r, type_n;
   logic          btn_prev;
   logic          hit_n;
   logic [5:0]    dmg_n;
   logic          press, hit_ok;

   // Hitbox / hurtbox overlap in 11-bit signed space
   logic signed [10:0] ax, ay, dx, dy, reach;
   logic signed [10:0] hb_lo, hb_hi, hu_lo, hu_hi, y_lo, y_hi;
   logic               overlap;

   always_comb begin
      ax    = $signed({1'b0, atk_x});
      ay    = $signed({1'b0, atk_y});
      dx    = $signed({1'b0, def_x});
      dy    = $signed({1'b0, def_y});
      reach = type_r ? 11'(SMASH_REACH) : 11'(JAB_REACH);
      hb_lo = facing ? ax : ax - reach;
      hb_hi = facing ? ax + reach : ax;
      hu_lo = dx - 11'(HURTBOX_HALF_W);
      hu_hi = dx + 11'(HURTBOX_HALF_W);
      y_lo  = ay - 11'(HITBOX_HALF_H);
      y_hi  = ay + 11'(HITBOX_HALF_H);
      overlap = (hb_lo <= hu_hi) && (hu_lo <= hb_hi) && (dy >= y_lo) && (dy <= y_hi);
   end

   assign press  = attack_btn & ~btn_prev;
   assign hit_ok = (state == S_ACTIVE) & overlap & ~hit_done & ~stunned;

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      pending_n  = pending | (press & ((state == S_IDLE) | (state == S_RECOVERY)));
      hit_done_n = hit_done;
      type_n     = type_r;
      hit_n      = 1'b0;
      dmg_n      = hit_damage_out;
      if ((state != S_IDLE) && stunned) begin
         state_n   = S_IDLE;
         cnt_n     = '0;
         pending_n = 1'b0;
      end else begin
         if (hit_ok) begin
            hit_done_n = 1'b1;
            hit_n      = 1'b1;
            dmg_n      = type_r ? 6'(SMASH_DAMAGE) : 6'(JAB_DAMAGE);
         end
         if (frame_tick) begin
            case (state)
               S_IDLE: begin
                  if (pending_n && !stunned) begin
                     state_n    = S_STARTUP;
                     cnt_n      = CNT_STARTUP;
                     pending_n  = 1'b0;
                     type_n     = attack_type;
                     hit_done_n = 1'b0;
                  end
               end
               S_STARTUP: begin
                  if (cnt == CNT_ONE) begin
                     state_n = S_ACTIVE;
                     cnt_n   = CNT_ACTIVE;
                  end else begin
                     cnt_n = cnt - CNT_ONE;
                  end
               end
               S_ACTIVE: begin
                  if (cnt == CNT_ONE) begin
                     state_n = S_RECOVERY;
                     cnt_n   = CNT_RECOVERY;
                  end else begin
                     cnt_n = cnt - CNT_ONE;
                  end
               end
               default: begin
                  if (cnt != CNT_ONE) begin
                     cnt_n = cnt - CNT_ONE;
                  end else if (pending_n) begin
                     // Buffered press chains straight into the next attack
                     state_n    = S_STARTUP;
                     cnt_n      = CNT_STARTUP;
                     pending_n  = 1'b0;
                     type_n     = attack_type;
                     hit_done_n = 1'b0;
                  end else begin
                     state_n = S_IDLE;
                     cnt_n   = '0;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         pending        <= 1'b0;
         hit_done       <= 1'b0;
         type_r         <= 1'b0;
         btn_prev       <= 1'b0;
         hit_out        <= 1'b0;
         hit_damage_out <= '0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         pending        <= pending_n;
         hit_done       <= hit_done_n;
         type_r         <= type_n;
         btn_prev       <= attack_btn;
         hit_out        <= hit_n;
         hit_damage_out <= dmg_n;
      end
   end

   assign attack_phase = state;
   assign attack_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_attack_fsm.sv
// Directed self-checking bench for attack_fsm: phase timing, hit detection,
// stun cancel, buffered presses and asynchronous reset.
module tb_attack_fsm;

   logic       clk;
   logic       reset_n;
   logic       frame_tick;
   logic       attack_btn;
   logic       attack_type;
   logic       facing;
   logic       stunned;
   logic [9:0] atk_x, atk_y, def_x, def_y;
   logic       hit_out;
   logic [5:0] hit_damage_out;
   logic [1:0] attack_phase;
   logic       attack_busy;

   int tests = 0;
   int fails = 0;
   int hit_cnt = 0;

   attack_fsm dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .frame_tick     (frame_tick),
      .attack_btn     (attack_btn),
      .attack_type    (attack_type),
      .facing         (facing),
      .stunned        (stunned),
      .atk_x          (atk_x),
      .atk_y          (atk_y),
      .def_x          (def_x),
      .def_y          (def_y),
      .hit_out        (hit_out),
      .hit_damage_out (hit_damage_out),
      .attack_phase   (attack_phase),
      .attack_busy    (attack_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every clk with hit_out high is one pulse-cycle
   always @(negedge clk) if (hit_out === 1'b1) hit_cnt++;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press();
      attack_btn = 1'b1;
      step();
      attack_btn = 1'b0;
      step();
   endtask

   task automatic tick();
      step();
      step();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic run(input string tag, input int n, input int p);
      for (int i = 0; i < n; i++) begin
         tick();
         check(tag, 32'(attack_phase), p);
         check({tag, "_busy"}, 32'(attack_busy), (p != 0) ? 1 : 0);
      end
   endtask

   // From the STARTUP entry tick to the return to IDLE
   task automatic rest_of_attack(input string tag);
      run({tag, "_st"}, 3, 1);
      run({tag, "_st2act"}, 1, 2);
      run({tag, "_act"}, 2, 2);
      run({tag, "_act2rec"}, 1, 3);
      run({tag, "_rec"}, 7, 3);
      run({tag, "_rec2idle"}, 1, 0);
   endtask

   initial begin
      reset_n = 1'b0; frame_tick = 1'b0; attack_btn = 1'b0; attack_type = 1'b0;
      facing = 1'b1; stunned = 1'b0;
      atk_x = 10'd100; atk_y = 10'd100; def_x = 10'd500; def_y = 10'd100;
      #22;
      check("rst_phase", 32'(attack_phase), 0);
      check("rst_busy", 32'(attack_busy), 0);
      check("rst_hit", 32'(hit_out), 0);
      check("rst_dmg", 32'(hit_damage_out), 0);
      reset_n = 1'b1;
      step();

      // Jab, no overlap
      hit_cnt = 0;
      press();
      run("t1_start", 1, 1);
      rest_of_attack("t1");
      check("t1_hits", hit_cnt, 0);

      // Jab facing right, defender inside reach for all active frames
      def_x = 10'd125; hit_cnt = 0;
      press();
      run("t2_start", 1, 1);
      run("t2_st", 3, 1);
      step(); step();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("t2_active", 32'(attack_phase), 2);
      check("t2_no_hit_yet", 32'(hit_out), 0);
      step();
      check("t2_hit", 32'(hit_out), 1);
      check("t2_dmg", 32'(hit_damage_out), 6);
      step();
      check("t2_hit_end", 32'(hit_out), 0);
      run("t2_act", 2, 2);
      run("t2_act2rec", 1, 3);
      run("t2_rec", 7, 3);
      run("t2_rec2idle", 1, 0);
      check("t2_hits", hit_cnt, 1);
      check("t2_dmg_hold", 32'(hit_damage_out), 6);

      // Smash facing left, near edge of reach
      attack_type = 1'b1; facing = 1'b0; def_x = 10'd60; def_y = 10'd110; hit_cnt = 0;
      press();
      run("t3_start", 1, 1);
      rest_of_attack("t3");
      check("t3_hits", hit_cnt, 1);
      check("t3_dmg", 32'(hit_damage_out), 14);

      // Same but defender just above vertical range
      def_y = 10'd117; hit_cnt = 0;
      press();
      run("t3b_start", 1, 1);
      rest_of_attack("t3b");
      check("t3b_hits", hit_cnt, 0);

      // Stun cancel on 2nd startup tick, then press while stunned
      attack_type = 1'b0; facing = 1'b1; def_x = 10'd125; def_y = 10'd100; hit_cnt = 0;
      press();
      run("t4_start", 1, 1);
      run("t4_st", 1, 1);
      step();
      stunned = 1'b1;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("t4_cancel", 32'(attack_phase), 0);
      check("t4_cancel_busy", 32'(attack_busy), 0);
      def_x = 10'd500;
      press();
      run("t4_stunned_idle", 2, 0);
      stunned = 1'b0;
      step();
      check("t4_wait_tick", 32'(attack_phase), 0);
      run("t4_restart", 1, 1);
      rest_of_attack("t4");
      check("t4_hits", hit_cnt, 0);

      // Buffered press during recovery chains into startup
      press();
      run("t5_start", 1, 1);
      run("t5_st", 3, 1);
      run("t5_st2act", 1, 2);
      run("t5_act", 2, 2);
      run("t5_act2rec", 1, 3);
      run("t5_rec", 4, 3);
      press();
      run("t5_rec_late", 3, 3);
      run("t5_chain", 1, 1);
      press();
      rest_of_attack("t5b");
      run("t5_no_buffer", 1, 0);

      // Async reset while a hit pulse is high
      def_x = 10'd125;
      press();
      run("t6_start", 1, 1);
      run("t6_st", 3, 1);
      step(); step();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      check("t6_hit", 32'(hit_out), 1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_phase", 32'(attack_phase), 0);
      check("t6_rst_busy", 32'(attack_busy), 0);
      check("t6_rst_hit", 32'(hit_out), 0);
      check("t6_rst_dmg", 32'(hit_damage_out), 0);
      #10 reset_n = 1'b1;
      step();

      // Press edge and frame_tick in the same clk start the attack on that tick
      def_x = 10'd500; hit_cnt = 0;
      step();
      attack_btn = 1'b1;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      attack_btn = 1'b0;
      check("t6_same_clk_start", 32'(attack_phase), 1);
      rest_of_attack("t6");
      check("t6_hits", hit_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
